nios_debug_cmd_dispatch: RTL and testbench

NIOS_DEBUG_CMD_DISPATCH -- requirements
Module: nios_debug_cmd_dispatch

---
 rtl/nios_debug_cmd_dispatch.sv | 160 ++++++++++++++++
 tb/tb_nios_debug_cmd_dispatch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_cmd_dispatch.sv
// Debug command dispatcher: brings JTAG update-DR/IR strobes into clk, captures one
// command at a time and issues a one-hot action/no-action strobe per channel.

module nios_debug_cmd_dispatch_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_level,
  output logic o_pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_valid;
  logic                   r_prev;
  logic                   r_arm;
  logic                   r_pulse;

  // Synchroniser plus rising-edge detect; r_arm stays low until a genuine low level
  // has come through, so a level already high at reset release never pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= {SYNC_STAGES{1'b0}};
      r_valid <= {SYNC_STAGES{1'b0}};
      r_prev  <= 1'b0;
      r_arm   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_level};
      r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
      r_prev  <= r_sync[SYNC_STAGES-1];
      if (r_valid[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) begin
        r_arm <= 1'b1;
      end
      r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev & r_arm;
    end
  end

  assign o_pulse = r_pulse;
endmodule

module nios_debug_cmd_dispatch #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = DATA_W - 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DATA_W-1:0]    sr,
  input  logic [2**IR_W-1:0]   ch_busy,
  input  logic                 overflow_clr,
  output logic [DATA_W-1:0]    jdo,
  output logic [IR_W-1:0]      ir_latched,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 cmd_pending,
  output logic                 overflow
);
  localparam int NUM_CH = 2**IR_W;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_jdo;
  logic [IR_W-1:0]     r_ir_latched;
  logic [NUM_CH-1:0]   r_take_action;
  logic [NUM_CH-1:0]   r_take_no_action;
  logic                r_overflow;

  logic                w_udr_pulse;
  logic                w_uir_pulse;
  logic                w_busy;
  logic [NUM_CH-1:0]   w_sel;
  logic                w_ovf_set;

  nios_debug_cmd_dispatch_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (vs_udr),
    .o_pulse (w_udr_pulse)
  );

  nios_debug_cmd_dispatch_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (vs_uir),
    .o_pulse (w_uir_pulse)
  );

  assign w_busy = ch_busy[r_ir_latched];
  assign w_sel  = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ir_latched;

  // A drop happens only when a new update arrives while the pending command is stuck.
  always_comb begin
    w_ovf_set = 1'b0;
    if ((r_state == ST_PEND) && w_udr_pulse && !w_uir_pulse && w_busy) begin
      w_ovf_set = 1'b1;
    end else begin
      w_ovf_set = 1'b0;
    end
  end

  // Command FSM with registered strobes; abort beats dispatch, dispatch frees the slot
  // for an update landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_jdo            <= {DATA_W{1'b0}};
      r_ir_latched     <= {IR_W{1'b0}};
      r_take_action    <= {NUM_CH{1'b0}};
      r_take_no_action <= {NUM_CH{1'b0}};
      r_overflow       <= 1'b0;
    end else begin
      r_take_action    <= {NUM_CH{1'b0}};
      r_take_no_action <= {NUM_CH{1'b0}};
      case (r_state)
        ST_IDLE: begin
          if (w_udr_pulse) begin
            r_jdo        <= sr;
            r_ir_latched <= ir_in;
            r_state      <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_uir_pulse) begin
            r_state <= ST_IDLE;
          end else if (!w_busy) begin
            if (r_jdo[ACT_BIT]) begin
              r_take_action <= w_sel;
            end else begin
              r_take_no_action <= w_sel;
            end
            if (w_udr_pulse) begin
              r_jdo        <= sr;
              r_ir_latched <= ir_in;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign jdo            = r_jdo;
  assign ir_latched     = r_ir_latched;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign cmd_pending    = (r_state == ST_PEND);
  assign overflow       = r_overflow;
endmodule

// File: tb/tb_nios_debug_cmd_dispatch.sv
// Directed bench: default instance for command handling, plus a wide instance for the
// 8-channel, 3-stage-sync sweep.
module tb_nios_debug_cmd_dispatch;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr, vs_uir, overflow_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [3:0]  ch_busy;
  logic [37:0] jdo;
  logic [1:0]  ir_latched;
  logic [3:0]  ta, tna;
  logic        pend, ovf;

  logic        vs_udr_b, vs_uir_b, clr_b;
  logic [2:0]  ir_b;
  logic [63:0] sr_b;
  logic [7:0]  busy_b;
  logic [63:0] jdo_b;
  logic [2:0]  irl_b;
  logic [7:0]  ta_b, tna_b;
  logic        pend_b, ovf_b;
  logic [63:0] exp_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_debug_cmd_dispatch dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in),
    .sr(sr), .ch_busy(ch_busy), .overflow_clr(overflow_clr), .jdo(jdo),
    .ir_latched(ir_latched), .take_action(ta), .take_no_action(tna),
    .cmd_pending(pend), .overflow(ovf)
  );

  nios_debug_cmd_dispatch #(.DATA_W(64), .IR_W(3), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr_b), .vs_uir(vs_uir_b), .ir_in(ir_b),
    .sr(sr_b), .ch_busy(busy_b), .overflow_clr(clr_b), .jdo(jdo_b),
    .ir_latched(irl_b), .take_action(ta_b), .take_no_action(tna_b),
    .cmd_pending(pend_b), .overflow(ovf_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; overflow_clr = 1'b0;
    ir_in = 2'd0; sr = 38'h0; ch_busy = 4'h0;
    vs_udr_b = 1'b0; vs_uir_b = 1'b0; clr_b = 1'b0; ir_b = 3'd0; sr_b = 64'h0; busy_b = 8'h0;
    tick(3);
    check("rst_jdo", 64'(jdo), 64'h0);
    check("rst_strobes", 64'({ta, tna}), 64'h0);
    check("rst_pend_ovf", 64'({pend, ovf, ir_latched}), 64'h0);
    reset_n = 1'b1;
    tick(6);

    // Basic action dispatch and latency (strobe at edge 5)
    sr = 38'h20_0000_00A5; ir_in = 2'd2; vs_udr = 1'b1;
    tick(4);
    check("lat_early_ta", 64'(ta), 64'h0);
    check("lat_pend", 64'(pend), 64'h1);
    tick(1);
    check("act_ta", 64'(ta), 64'h4);
    check("act_tna", 64'(tna), 64'h0);
    check("act_jdo", 64'(jdo), 64'h20_0000_00A5);
    check("act_ir", 64'(ir_latched), 64'h2);
    tick(1);
    check("act_one_cycle", 64'(ta), 64'h0);
    vs_udr = 1'b0;
    tick(4);

    // Back-pressure: no-action held while channel 1 busy
    sr = 38'h00_1234_5678; ir_in = 2'd1; ch_busy = 4'b0010; vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("busy_hold", 64'({pend, ta, tna}), 64'h100);
    end
    ch_busy = 4'h0;
    tick(1);
    check("busy_release_tna", 64'(tna), 64'h2);
    check("busy_release_ta_pend", 64'({ta, pend}), 64'h0);
    tick(1);
    check("busy_release_one", 64'(tna), 64'h0);
    tick(3);

    // Overflow on drop, clear, and set-beats-clear
    sr = 38'h20_0000_0011; ir_in = 2'd3; ch_busy = 4'b1000; vs_udr = 1'b1;
    tick(4);
    check("ovf_first_pend", 64'(pend), 64'h1);
    vs_udr = 1'b0;
    tick(3);
    sr = 38'h20_0000_0022; ir_in = 2'd0; vs_udr = 1'b1;
    tick(4);
    check("ovf_set", 64'(ovf), 64'h1);
    check("ovf_jdo_kept", 64'(jdo), 64'h20_0000_0011);
    vs_udr = 1'b0;
    tick(3);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", 64'(ovf), 64'h0);
    tick(2);
    sr = 38'h20_0000_0033; vs_udr = 1'b1;
    tick(3);
    check("ovf_before_set", 64'(ovf), 64'h0);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_set_beats_clr", 64'(ovf), 64'h1);
    vs_udr = 1'b0;
    tick(3);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    ch_busy = 4'h0;
    tick(1);
    check("ovf_drain_ta", 64'(ta), 64'h8);
    check("ovf_drain_jdo", 64'(jdo), 64'h20_0000_0011);
    check("ovf_cleared", 64'(ovf), 64'h0);
    tick(3);

    // Update landing in the dispatch cycle is accepted
    sr = 38'h20_0000_0055; ir_in = 2'd0; ch_busy = 4'b0001; vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(4);
    sr = 38'h00_0000_0066; ir_in = 2'd1; vs_udr = 1'b1;
    tick(3);
    ch_busy = 4'h0;
    tick(1);
    check("same_cycle_ta", 64'(ta), 64'h1);
    check("same_cycle_jdo", 64'(jdo), 64'h00_0000_0066);
    check("same_cycle_pend_ovf", 64'({pend, ovf}), 64'h2);
    vs_udr = 1'b0;
    tick(1);
    check("same_cycle_second_tna", 64'(tna), 64'h2);
    check("same_cycle_done", 64'({ta, pend}), 64'h0);
    tick(3);

    // Abort via update-IR
    sr = 38'h20_0000_0044; ir_in = 2'd0; ch_busy = 4'b0001; vs_udr = 1'b1;
    tick(4);
    check("abort_pend_before", 64'(pend), 64'h1);
    vs_udr = 1'b0;
    tick(2);
    vs_uir = 1'b1;
    tick(4);
    check("abort_pend", 64'(pend), 64'h0);
    vs_uir = 1'b0;
    ch_busy = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("abort_no_strobe", 64'({ta, tna, pend}), 64'h0);
    end

    // Reset mid-PEND with vs_udr still high
    sr = 38'h20_0000_0077; ir_in = 2'd2; ch_busy = 4'b0100; vs_udr = 1'b1;
    tick(4);
    check("rst_mid_pend_before", 64'(pend), 64'h1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outs", 64'({ta, tna, pend, ovf, ir_latched}), 64'h0);
    check("rst_mid_jdo", 64'(jdo), 64'h0);
    tick(2);
    reset_n = 1'b1;
    ch_busy = 4'h0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("rst_release_quiet", 64'({ta, tna, pend}), 64'h0);
    end
    vs_udr = 1'b0;
    tick(3);
    vs_udr = 1'b1;
    tick(4);
    check("rst_rearm_early", 64'(ta), 64'h0);
    tick(1);
    check("rst_rearm_ta", 64'(ta), 64'h4);
    vs_udr = 1'b0;
    tick(4);

    // Wide instance: 8 channels, latency 6 edges
    for (int ch = 0; ch < 8; ch++) begin
      exp_b = {(ch % 2 == 0) ? 1'b1 : 1'b0, 63'(ch * 17 + 5)};
      sr_b = exp_b; ir_b = 3'(ch); vs_udr_b = 1'b1;
      tick(5);
      check("sweep_early", 64'({ta_b, tna_b}), 64'h0);
      tick(1);
      if (ch % 2 == 0) begin
        check("sweep_ta", 64'(ta_b), 64'(8'h1 << ch));
        check("sweep_tna_zero", 64'(tna_b), 64'h0);
      end else begin
        check("sweep_tna", 64'(tna_b), 64'(8'h1 << ch));
        check("sweep_ta_zero", 64'(ta_b), 64'h0);
      end
      check("sweep_jdo", jdo_b, exp_b);
      vs_udr_b = 1'b0;
      tick(5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
